// File: rtl/calculations.sv
`default_nettype none
// ============================================================================
// Module   : calculations
// Brief    : Execute stage of the 16-bit multi-cycle processor. Operand
//            muxes, ALU with zero/negative/carry flags, ALUOut and B
//            pipeline registers, and the next-PC mux.
// Options  : CALC_MUL_EN - when defined, ALUOp 11 is an unsigned multiply
//            (low WIDTH bits). When undefined, ALUOp 11 yields 0 and no
//            multiplier is built.
// Revision : 1.0 - initial release
// ============================================================================
module calculations #(
   parameter int WIDTH  = 16,
   parameter int PC_INC = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] input_A,
   input  logic [WIDTH-1:0] input_B,
   input  logic [WIDTH-1:0] input_PC,
   input  logic [WIDTH-1:0] input_imm,
   input  logic [1:0]       input_ALUSrcA,
   input  logic [1:0]       input_ALUSrcB,
   input  logic [3:0]       input_ALUOp,
   input  logic             input_PCSrc,
   output logic [WIDTH-1:0] output_ALUOut_sr,
   output logic [WIDTH-1:0] output_B_sr,
   output logic [WIDTH-1:0] output_ALUMuxOut,
   output logic             output_Zero,
   output logic             output_negative,
   output logic             output_carry
);

   localparam logic [3:0] OP_ADD    = 4'd0;
   localparam logic [3:0] OP_SUB    = 4'd1;
   localparam logic [3:0] OP_AND    = 4'd2;
   localparam logic [3:0] OP_OR     = 4'd3;
   localparam logic [3:0] OP_XOR    = 4'd4;
   localparam logic [3:0] OP_NOR    = 4'd5;
   localparam logic [3:0] OP_SLL    = 4'd6;
   localparam logic [3:0] OP_SRL    = 4'd7;
   localparam logic [3:0] OP_SRA    = 4'd8;
   localparam logic [3:0] OP_SLT    = 4'd9;
   localparam logic [3:0] OP_PASS_B = 4'd10;
   localparam logic [3:0] OP_MUL    = 4'd11;

   localparam logic [WIDTH-1:0] PC_INC_VAL = WIDTH'(PC_INC);

   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH:0]   add_sum;
   logic [WIDTH:0]   sub_sum;
   logic [WIDTH-1:0] alu_res;
   logic             alu_carry;
   logic             slt_bit;
   logic [WIDTH-1:0] aluout_sr;
   logic [WIDTH-1:0] b_sr;

   // Operand selection: A from PC/register/zero, B from register/PC step/immediate forms
   always_comb begin
      op_a = '0;
      op_b = '0;
      case (input_ALUSrcA)
         2'd0:    op_a = input_PC;
         2'd1:    op_a = input_A;
         default: op_a = '0;
      endcase
      case (input_ALUSrcB)
         2'd0:    op_b = input_B;
         2'd1:    op_b = PC_INC_VAL;
         2'd2:    op_b = input_imm;
         default: op_b = {input_imm[WIDTH-2:0], 1'b0};
      endcase
   end

   // Shared 17-bit sums so carry-out is bit WIDTH; SUB carry=1 means no borrow
   always_comb begin
      add_sum = {1'b0, op_a} + {1'b0, op_b};
      sub_sum = {1'b0, op_a} + {1'b0, ~op_b} + {{WIDTH{1'b0}}, 1'b1};
      slt_bit = ($signed(op_a) < $signed(op_b));
   end

   // ALU operation decode; carry is only meaningful for ADD/SUB
   always_comb begin
      alu_res   = '0;
      alu_carry = 1'b0;
      case (input_ALUOp)
         OP_ADD: begin
            alu_res   = add_sum[WIDTH-1:0];
            alu_carry = add_sum[WIDTH];
         end
         OP_SUB: begin
            alu_res   = sub_sum[WIDTH-1:0];
            alu_carry = sub_sum[WIDTH];
         end
         OP_AND:    alu_res = op_a & op_b;
         OP_OR:     alu_res = op_a | op_b;
         OP_XOR:    alu_res = op_a ^ op_b;
         OP_NOR:    alu_res = ~(op_a | op_b);
         OP_SLL:    alu_res = op_a << op_b[3:0];
         OP_SRL:    alu_res = op_a >> op_b[3:0];
         OP_SRA:    alu_res = $signed(op_a) >>> op_b[3:0];
         OP_SLT:    alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
         OP_PASS_B: alu_res = op_b;
`ifdef CALC_MUL_EN
         OP_MUL:    alu_res = op_a * op_b;
`else
         OP_MUL:    alu_res = '0;
`endif
         default:   alu_res = '0;
      endcase
   end

   // Flags and next-PC select are combinational so branches resolve same cycle
   always_comb begin
      output_Zero      = (alu_res == '0);
      output_negative  = alu_res[WIDTH-1];
      output_carry     = alu_carry;
      output_ALUMuxOut = input_PCSrc ? aluout_sr : alu_res;
   end

   // Pipeline registers: latch ALU result and store data every cycle, cleared on reset
   always_ff @(posedge clk) begin
      if (reset) begin
         aluout_sr <= '0;
         b_sr      <= '0;
      end else begin
         aluout_sr <= alu_res;
         b_sr      <= input_B;
      end
   end

   assign output_ALUOut_sr = aluout_sr;
   assign output_B_sr      = b_sr;

endmodule
`default_nettype wire

// File: tb/tb_calculations.sv
`default_nettype none
// ============================================================================
// Module   : tb_calculations
// Brief    : Directed self-checking bench for the calculations execute stage.
//            Expected values are hand-computed; CALC_MUL_EN selects the
//            expected ALUOp 11 result.
// Revision : 1.0 - initial release
// ============================================================================
module tb_calculations;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] input_A, input_B, input_PC, input_imm;
   logic [1:0]  input_ALUSrcA, input_ALUSrcB;
   logic [3:0]  input_ALUOp;
   logic        input_PCSrc;
   logic [15:0] output_ALUOut_sr, output_B_sr, output_ALUMuxOut;
   logic        output_Zero, output_negative, output_carry;

   int compared   = 0;
   int mismatched = 0;

   calculations #(.WIDTH(16), .PC_INC(2)) dut (
      .clk              (clk),
      .reset            (reset),
      .input_A          (input_A),
      .input_B          (input_B),
      .input_PC         (input_PC),
      .input_imm        (input_imm),
      .input_ALUSrcA    (input_ALUSrcA),
      .input_ALUSrcB    (input_ALUSrcB),
      .input_ALUOp      (input_ALUOp),
      .input_PCSrc      (input_PCSrc),
      .output_ALUOut_sr (output_ALUOut_sr),
      .output_B_sr      (output_B_sr),
      .output_ALUMuxOut (output_ALUMuxOut),
      .output_Zero      (output_Zero),
      .output_negative  (output_negative),
      .output_carry     (output_carry)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Drive a full operand set right after a falling edge
   task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [15:0] pc,
                        input logic [15:0] imm, input logic [1:0] sa, input logic [1:0] sb,
                        input logic [3:0] op, input logic pcs);
      @(negedge clk);
      input_A = a; input_B = b; input_PC = pc; input_imm = imm;
      input_ALUSrcA = sa; input_ALUSrcB = sb; input_ALUOp = op; input_PCSrc = pcs;
      #1;
   endtask

   // Check live result (PCSrc=0) and all three flags
   task automatic check_alu(input string tag, input logic [15:0] res,
                            input logic z, input logic n, input logic c);
      check({tag, "_res"}, output_ALUMuxOut, res);
      check({tag, "_zero"}, {15'd0, output_Zero}, {15'd0, z});
      check({tag, "_neg"}, {15'd0, output_negative}, {15'd0, n});
      check({tag, "_carry"}, {15'd0, output_carry}, {15'd0, c});
   endtask

   task automatic step_edge();
      @(posedge clk);
      #1;
   endtask

   logic [15:0] mul_expect;

   initial begin
`ifdef CALC_MUL_EN
      mul_expect = 16'd15;
`else
      mul_expect = 16'd0;
`endif
      reset = 1'b1;
      // Reset: combinational path still live, registers cleared
      drive(16'h0005, 16'h0003, 16'h0000, 16'h0000, 2'd1, 2'd0, 4'd0, 1'b0);
      check("reset_comb", output_ALUMuxOut, 16'h0008);
      step_edge();
      check("reset_aluout", output_ALUOut_sr, 16'h0000);
      check("reset_bsr", output_B_sr, 16'h0000);

      // PC increment
      drive(16'h0000, 16'hBEEF, 16'h0010, 16'h0000, 2'd0, 2'd1, 4'd0, 1'b0);
      reset = 1'b0;
      check_alu("pc_inc", 16'h0012, 1'b0, 1'b0, 1'b0);
      step_edge();
      check("pc_inc_aluout", output_ALUOut_sr, 16'h0012);
      check("pc_inc_bsr", output_B_sr, 16'hBEEF);

      // SUB equal and SUB borrow
      drive(16'h1234, 16'h1234, 16'h0000, 16'h0000, 2'd1, 2'd0, 4'd1, 1'b0);
      check_alu("sub_eq", 16'h0000, 1'b1, 1'b0, 1'b1);
      drive(16'h0001, 16'h0002, 16'h0000, 16'h0000, 2'd1, 2'd0, 4'd1, 1'b0);
      check_alu("sub_borrow", 16'hFFFF, 1'b0, 1'b1, 1'b0);

      // ADD wrap with carry
      drive(16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 2'd1, 2'd0, 4'd0, 1'b0);
      check_alu("add_wrap", 16'h0000, 1'b1, 1'b0, 1'b1);

      // Branch target: PC + (imm<<1), then select stored target with a different live value
      drive(16'h0000, 16'h0000, 16'h0020, 16'hFFFE, 2'd0, 2'd3, 4'd0, 1'b0);
      check_alu("br_calc", 16'h001C, 1'b0, 1'b0, 1'b1);
      step_edge();
      check("br_aluout", output_ALUOut_sr, 16'h001C);
      drive(16'h0000, 16'h0000, 16'h0040, 16'hFFFE, 2'd0, 2'd3, 4'd0, 1'b1);
      check("br_pcsrc1", output_ALUMuxOut, 16'h001C);
      input_PCSrc = 1'b0;
      #1;
      check("br_live", output_ALUMuxOut, 16'h003C);

      // Logic ops
      drive(16'hF0F0, 16'hFF00, 16'h0000, 16'h0000, 2'd1, 2'd0, 4'd2, 1'b0);
      check("and", output_ALUMuxOut, 16'hF000);
      drive(16'hF0F0, 16'hFF00, 16'h0000, 16'h0000, 2'd1, 2'd0, 4'd3, 1'b0);
      check("or", output_ALUMuxOut, 16'hFFF0);
      drive(16'hF0F0, 16'hFF00, 16'h0000, 16'h0000, 2'd1, 2'd0, 4'd4, 1'b0);
      check("xor", output_ALUMuxOut, 16'h0FF0);
      drive(16'hF0F0, 16'hFF00, 16'h0000, 16'h0000, 2'd1, 2'd0, 4'd5, 1'b0);
      check_alu("nor", 16'h000F, 1'b0, 1'b0, 1'b0);

      // Shifts (amount from B[3:0] only)
      drive(16'h0001, 16'h0014, 16'h0000, 16'h0000, 2'd1, 2'd0, 4'd6, 1'b0);
      check("sll", output_ALUMuxOut, 16'h0010);
      drive(16'h8000, 16'h0003, 16'h0000, 16'h0000, 2'd1, 2'd0, 4'd7, 1'b0);
      check("srl", output_ALUMuxOut, 16'h1000);
      drive(16'h8000, 16'h0000, 16'h0000, 16'h0004, 2'd1, 2'd2, 4'd8, 1'b0);
      check_alu("sra", 16'hF800, 1'b0, 1'b1, 1'b0);

      // SLT signed
      drive(16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 2'd1, 2'd0, 4'd9, 1'b0);
      check("slt_true", output_ALUMuxOut, 16'h0001);
      drive(16'h0001, 16'hFFFF, 16'h0000, 16'h0000, 2'd1, 2'd0, 4'd9, 1'b0);
      check("slt_false", output_ALUMuxOut, 16'h0000);

      // PASS_B, zero A-operand sources, reserved op
      drive(16'h1111, 16'hABCD, 16'h0000, 16'h0000, 2'd1, 2'd0, 4'd10, 1'b0);
      check("pass_b", output_ALUMuxOut, 16'hABCD);
      drive(16'h1111, 16'h0000, 16'h2222, 16'h0007, 2'd2, 2'd2, 4'd0, 1'b0);
      check("srca2_zero", output_ALUMuxOut, 16'h0007);
      drive(16'h1111, 16'h0000, 16'h2222, 16'h0007, 2'd3, 2'd2, 4'd0, 1'b0);
      check("srca3_zero", output_ALUMuxOut, 16'h0007);
      drive(16'h1234, 16'h5678, 16'h0000, 16'h0000, 2'd1, 2'd0, 4'd12, 1'b0);
      check_alu("op12", 16'h0000, 1'b1, 1'b0, 1'b0);

      // ALUOp 11: multiply when enabled, else zero
      drive(16'h0003, 16'h0005, 16'h0000, 16'h0000, 2'd1, 2'd0, 4'd11, 1'b0);
      check_alu("op11", mul_expect, (mul_expect == 16'd0), 1'b0, 1'b0);

      // Mid-instruction reset discards the latched result
      drive(16'h0100, 16'h0200, 16'h0000, 16'h0000, 2'd1, 2'd0, 4'd0, 1'b0);
      step_edge();
      check("mid_load", output_ALUOut_sr, 16'h0300);
      check("mid_load_b", output_B_sr, 16'h0200);
      drive(16'h0100, 16'h0200, 16'h0000, 16'h0000, 2'd1, 2'd0, 4'd0, 1'b0);
      reset = 1'b1;
      step_edge();
      check("mid_reset", output_ALUOut_sr, 16'h0000);
      check("mid_reset_b", output_B_sr, 16'h0000);
      @(negedge clk);
      reset = 1'b0;
      step_edge();
      check("post_reset", output_ALUOut_sr, 16'h0300);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire
